// File: rtl/sfifo_pkg.sv
// Shared definitions for the synchronous FIFO write-side front end.
// Holds the burst FSM state encoding and the FIFO depth derivation.
package sfifo_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_e;

    function automatic int DATA_NUM(input int pointer_width);
        return 1 << pointer_width;
    endfunction

endpackage

// File: rtl/sfifo_skid2.sv
// Two-entry in-order skid buffer. Entry 0 is always the head, so a pop
// shifts entry 1 down; both entries reset to zero so the head reads 0.
module sfifo_skid2 #(
    parameter int W = 9
) (
    input  logic         wclk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic [1:0]   count_q;
    logic [1:0]   count_d;

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10: begin
                mem_d[count_q[0]] = push_data_i;
                count_d           = count_q + 2'd1;
            end
            2'b01: begin
                mem_d[0] = mem_q[1];
                count_d  = count_q - 2'd1;
            end
            2'b11: begin
                // With one entry the new word becomes the head directly.
                mem_d[0] = (count_q == 2'd2) ? mem_q[1] : push_data_i;
                mem_d[1] = (count_q == 2'd2) ? push_data_i : mem_q[1];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[0];

endmodule

// File: rtl/sfifo_burst_writer.sv
// Write-side front end: buffers a valid/ready stream and writes it into the
// FIFO in bursts that only start once a whole burst's worth of space is free.
module sfifo_burst_writer
    import sfifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int POINTER_WIDTH = 4,
    parameter int BURST_LEN     = 4
) (
    input  logic                     wclk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     s_last,
    output logic                     s_ready,
    input  logic [POINTER_WIDTH:0]   fifo_level,
    input  logic                     fifo_full,
    output logic                     fifo_wr,
    output logic [DATA_WIDTH-1:0]    fifo_data,
    output logic                     burst_done,
    output logic                     busy,
    output logic                     err_full
);

    localparam int                   DEPTH     = DATA_NUM(POINTER_WIDTH);
    localparam int                   BEAT_W    = $clog2(BURST_LEN + 1);
    localparam logic [POINTER_WIDTH:0] DEPTH_W = (POINTER_WIDTH + 1)'(DEPTH);
    localparam logic [POINTER_WIDTH:0] BURST_W = (POINTER_WIDTH + 1)'(BURST_LEN);
    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [1:0]             count;
    logic [DATA_WIDTH:0]    head;
    logic                   push;
    logic [POINTER_WIDTH:0] free;
    logic                   burst_end;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              err_q, err_d;

    assign s_ready   = (count != 2'd2);
    assign push      = s_valid & s_ready;
    assign free      = DEPTH_W - fifo_level;
    assign fifo_data = head[DATA_WIDTH-1:0];
    assign burst_end = head[DATA_WIDTH] | (beat_q == LAST_BEAT);
    assign err_full  = err_q;

    sfifo_skid2 #(
        .W (DATA_WIDTH + 1)
    ) u_skid (
        .wclk        (wclk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({s_last, s_data}),
        .pop_i       (fifo_wr),
        .count_o     (count),
        .head_o      (head)
    );

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The free-space reservation is only taken in IDLE; reads during a burst only add room.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if ((count != 2'd0) && (free >= BURST_W)) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (fifo_wr && burst_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_wr    = 1'b0;
        burst_done = 1'b0;
        busy       = 1'b0;
        case (state_q)
            ST_BURST: begin
                busy       = 1'b1;
                fifo_wr    = (count != 2'd0) & ~fifo_full;
                burst_done = (count != 2'd0) & ~fifo_full & burst_end;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        beat_d = beat_q;
        if ((state_q == ST_IDLE) && (state_d == ST_BURST)) begin
            beat_d = '0;
        end else if (fifo_wr) begin
            beat_d = beat_q + BEAT_W'(1);
        end
        err_d = err_q | (busy & (count != 2'd0) & fifo_full);
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            beat_q <= beat_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_sfifo_burst_writer.sv
// Self-checking bench for sfifo_burst_writer: a scoreboard of expected writes
// plus a free-space gating table and hand-written multi-cycle sequences.
module tb_sfifo_burst_writer;

    localparam int BURST_LEN = 4;

    logic       wclk;
    logic       rst_n;
    logic       sValid;
    logic [7:0] sData;
    logic       sLast;
    logic       sReady;
    logic [4:0] fifoLevel;
    logic       fifoFull;
    logic       fifoWr;
    logic [7:0] fifoData;
    logic       burstDone;
    logic       busy;
    logic       errFull;

    typedef struct {
        logic [7:0] data;
        logic       done;
    } sbEntry_t;

    typedef struct {
        logic [4:0] level;
        logic [7:0] data;
        int         expWrites;
        logic [4:0] releaseLevel;
    } levelVec_t;

    sbEntry_t  sbQ[$];
    levelVec_t vecs[5];

    int compared      = 0;
    int mismatched    = 0;
    int wrCount       = 0;
    int doneCount     = 0;
    int cyc           = 0;
    int modelPos      = 0;
    int lastAcceptCyc = 0;
    int firstWrCyc    = -1;
    bit checkIdleNext = 0;

    sfifo_burst_writer #(
        .DATA_WIDTH    (8),
        .POINTER_WIDTH (4),
        .BURST_LEN     (BURST_LEN)
    ) dut (
        .wclk       (wclk),
        .rst_n      (rst_n),
        .s_valid    (sValid),
        .s_data     (sData),
        .s_last     (sLast),
        .s_ready    (sReady),
        .fifo_level (fifoLevel),
        .fifo_full  (fifoFull),
        .fifo_wr    (fifoWr),
        .fifo_data  (fifoData),
        .burst_done (burstDone),
        .busy       (busy),
        .err_full   (errFull)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    always @(posedge wclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one word, waits (bounded) for s_ready, and records the expected write.
    task automatic applyStimulus(input logic [7:0] d, input logic l);
        int  guard = 0;
        bit  expDone;
        sValid = 1'b1;
        sData  = d;
        sLast  = l;
        while (!sReady && guard < 200) begin
            @(negedge wclk);
            guard++;
        end
        if (!sReady) begin
            checkOutput("accept_timeout", 32'(sReady), 32'd1);
        end else begin
            expDone  = l || (modelPos == BURST_LEN - 1);
            modelPos = expDone ? 0 : modelPos + 1;
            sbQ.push_back('{data: d, done: expDone});
            @(posedge wclk);
            #1;
            lastAcceptCyc = cyc;
        end
        sValid = 1'b0;
        sLast  = 1'b0;
    endtask

    task automatic waitDrain();
        int guard = 0;
        while (sbQ.size() != 0 && guard < 100) begin
            @(negedge wclk);
            guard++;
        end
        @(negedge wclk);
        checkOutput("drain", 32'(sbQ.size()), 32'd0);
    endtask

    // Scoreboard side: every FIFO write must match the oldest expected word.
    always @(negedge wclk) begin
        if (rst_n) begin
            if (checkIdleNext) begin
                checkOutput("idle_after_burst", 32'(busy), 32'd0);
                checkIdleNext = 0;
            end
            if (fifoWr) begin
                sbEntry_t exp;
                wrCount++;
                if (firstWrCyc < 0) firstWrCyc = cyc + 1;
                if (burstDone) doneCount++;
                checkOutput("wr_in_burst", 32'(busy), 32'd1);
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_wr", 32'(fifoData), 32'hFFFF_FFFF);
                end else begin
                    exp = sbQ.pop_front();
                    checkOutput("wr_data", 32'(fifoData), 32'(exp.data));
                    checkOutput("burst_done", 32'(burstDone), 32'(exp.done));
                end
                if (burstDone) checkIdleNext = 1;
            end
        end
    end

    initial begin
        int startW;
        int startD;

        vecs[0] = '{level: 5'd16, data: 8'hA1, expWrites: 0, releaseLevel: 5'd0};
        vecs[1] = '{level: 5'd13, data: 8'hAA, expWrites: 0, releaseLevel: 5'd12};
        vecs[2] = '{level: 5'd12, data: 8'hAB, expWrites: 1, releaseLevel: 5'd12};
        vecs[3] = '{level: 5'd15, data: 8'hAC, expWrites: 0, releaseLevel: 5'd0};
        vecs[4] = '{level: 5'd0,  data: 8'hAD, expWrites: 1, releaseLevel: 5'd0};

        rst_n     = 1'b0;
        sValid    = 1'b0;
        sData     = 8'h00;
        sLast     = 1'b0;
        fifoLevel = 5'd0;
        fifoFull  = 1'b0;
        repeat (3) @(negedge wclk);
        checkOutput("reset_wr", 32'(fifoWr), 32'd0);
        checkOutput("reset_done", 32'(burstDone), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_err", 32'(errFull), 32'd0);
        checkOutput("reset_ready", 32'(sReady), 32'd1);
        checkOutput("reset_data", 32'(fifoData), 32'd0);
        rst_n = 1'b1;
        @(negedge wclk);

        $display("[TB] two full bursts from a continuous stream");
        startW = wrCount;
        startD = doneCount;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'(8'h10 + i), 1'b0);
            if (i == 0) startD = doneCount + (lastAcceptCyc - lastAcceptCyc);
            if (i == 0) firstWrCyc = -1;
            if (i == 0) startW = lastAcceptCyc;
        end
        waitDrain();
        checkOutput("first_wr_latency", 32'(firstWrCyc - startW), 32'd2);
        checkOutput("stream_done_pulses", 32'(doneCount - startD), 32'd2);

        $display("[TB] free-space gating table");
        for (int i = 0; i < 5; i++) begin
            fifoLevel = vecs[i].level;
            startW    = wrCount;
            applyStimulus(vecs[i].data, 1'b1);
            repeat (4) @(negedge wclk);
            checkOutput("level_gate", 32'(wrCount - startW), 32'(vecs[i].expWrites));
            fifoLevel = vecs[i].releaseLevel;
            waitDrain();
        end
        fifoLevel = 5'd0;

        $display("[TB] early burst end on last marker");
        startD = doneCount;
        applyStimulus(8'h30, 1'b0);
        applyStimulus(8'h31, 1'b1);
        applyStimulus(8'h32, 1'b1);
        waitDrain();
        checkOutput("last_done_pulses", 32'(doneCount - startD), 32'd2);

        $display("[TB] upstream gap stalls the burst");
        startW = wrCount;
        applyStimulus(8'h40, 1'b0);
        waitDrain();
        for (int i = 0; i < 5; i++) begin
            @(negedge wclk);
            checkOutput("stall_busy", 32'(busy), 32'd1);
            checkOutput("stall_wr", 32'(fifoWr), 32'd0);
        end
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h42, 1'b0);
        applyStimulus(8'h43, 1'b0);
        waitDrain();
        checkOutput("gap_writes", 32'(wrCount - startW), 32'd4);

        $display("[TB] fifo_full blocks writes mid-burst");
        applyStimulus(8'h50, 1'b0);
        waitDrain();
        fifoFull = 1'b1;
        applyStimulus(8'h51, 1'b0);
        @(negedge wclk);
        checkOutput("full_block_wr1", 32'(fifoWr), 32'd0);
        checkOutput("full_block_busy", 32'(busy), 32'd1);
        applyStimulus(8'h52, 1'b0);
        @(negedge wclk);
        checkOutput("full_block_wr2", 32'(fifoWr), 32'd0);
        checkOutput("full_err_set", 32'(errFull), 32'd1);
        fifoFull = 1'b0;
        applyStimulus(8'h53, 1'b0);
        waitDrain();
        checkOutput("full_err_sticky", 32'(errFull), 32'd1);

        $display("[TB] reset in the middle of a burst");
        fifoFull = 1'b1;
        applyStimulus(8'h60, 1'b0);
        applyStimulus(8'h61, 1'b0);
        @(negedge wclk);
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_wr", 32'(fifoWr), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        checkOutput("mid_reset_done", 32'(burstDone), 32'd0);
        checkOutput("mid_reset_err", 32'(errFull), 32'd0);
        sbQ.delete();
        modelPos      = 0;
        checkIdleNext = 0;
        fifoFull      = 1'b0;
        repeat (2) @(negedge wclk);
        rst_n = 1'b1;
        @(negedge wclk);
        checkOutput("post_reset_ready", 32'(sReady), 32'd1);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        checkOutput("post_reset_wr", 32'(fifoWr), 32'd0);
        applyStimulus(8'h70, 1'b1);
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
